window_sum_accumulator: RTL and testbench
=========================================

# window_sum_accumulator

Downstream consumer of the three-way passthrough summing stage. It takes the 32-bit summed stream on a valid/ready handshake, accumulates WINDOW consecutive samples into a widened sum, and presents each window total (or a partial total on flush) on an output valid/ready port. It decouples the always-on combinational adder output from slower downstream consumers.

## Interface
- WIDTH, 32, input sample width (matches upstream io_out)
- WINDOW, 4, samples per window; integer ≥ 1
- ACC_WIDTH, WIDTH + clog2(WINDOW), width of the accumulated sum (derived; never overridden)
- CNT_WIDTH, clog2(WINDOW+1), width of the sample-count output (derived)

- clock  input  1  sole clock, rising edge
- reset_n  input  1  asynchronous, active-low reset; one clock, asynchronous active-low reset
- io_in_bits  input  WIDTH  sample from upstream summing stage, unsigned
- io_in_valid  input  1  sample present
- io_in_ready  output  1  block accepts sample this cycle
- io_flush  input  1  request early emission of a partial window
- io_out_bits  output  ACC_WIDTH  window sum
- io_out_count  output  CNT_WIDTH  samples contained in io_out_bits (1..WINDOW)
- io_out_valid  output  1  result held
- io_out_ready  input  1  downstream accepts result

## Operation
- Fire rules: in_fire = io_in_valid & io_in_ready; out_fire = io_out_valid & io_out_ready.
- State ACCUM: io_in_ready = 1, io_out_valid = 0. Registers acc (ACC_WIDTH) and cnt (CNT_WIDTH).
  - in_fire: acc += zero-extended io_in_bits; cnt += 1.
  - in_fire with cnt == WINDOW-1: load io_out_bits = acc + in, io_out_count = WINDOW, go to HOLD.
  - io_flush with (cnt > 0 or in_fire), window not completing: load io_out_bits = acc (+ in if in_fire), io_out_count = cnt (+1 if in_fire), go to HOLD.
  - io_flush with cnt == 0 and no in_fire: ignored.
- State HOLD: io_out_valid = 1; io_out_bits/io_out_count stable until out_fire. io_in_ready = io_out_ready (pass-through ready).
  - out_fire without in_fire: acc = 0, cnt = 0, go to ACCUM.
  - out_fire with in_fire: sample starts next window: acc = in, cnt = 1; if WINDOW == 1, reload output with in and count 1 and stay in HOLD; else go to ACCUM.
  - io_flush ignored in HOLD.
- Arithmetic: unsigned, no saturation; ACC_WIDTH guarantees no overflow for a full window.
- io_out_bits and io_out_count are registered; unspecified-free: they read 0 whenever io_out_valid = 0.

## Timing
- Reset (reset_n low, async): state ACCUM, acc = 0, cnt = 0, io_out_valid = 0, io_out_bits = 0, io_out_count = 0, io_in_ready = 1 after state settles (reads 1 during reset).
- Reset deassertion is used synchronously inside the block (registers leave reset on first rising edge after release); reset mid-window discards the partial sum with no output.
- Latency: result valid the cycle after the completing sample's in_fire (1 cycle).
- Throughput: one sample per cycle sustained when io_out_ready is held high; no bubble at window boundaries.
- io_in_ready depends combinationally on io_out_ready only in HOLD; no other comb path input→output.
- io_out_valid never drops without out_fire; io_out_bits never changes while io_out_valid = 1 and io_out_ready = 0.

## Test plan
- Reset then samples 1,2,3,4 back-to-back, io_out_ready = 1 -> cycle after 4th accept: io_out_valid = 1, io_out_bits = 10, io_out_count = 4; io_in_ready stays 1.
- Four samples of 0xFFFFFFFF -> io_out_bits = 0x3FFFFFFFC (34-bit), count 4; no wrap.
- Window 5,6,7,8 with io_out_ready = 0 for 3 cycles -> io_in_ready = 0, output holds 26 stable; ready high with sample 9 valid -> 26 consumed, 9 becomes first of next window (next result after 9,1,1,1 = 12).
- Samples 3,4 then io_flush -> io_out_bits = 7, io_out_count = 2; flush asserted with cnt = 0 and no sample -> no output; flush coincident with sample 5 after 3,4 -> 12, count 3.
- reset_n pulsed low asynchronously (mid-cycle) after 2 samples -> io_out_valid = 0 immediately; following 1,1,1,1 yields 4, count 4.
- WINDOW = 1 build, continuous samples 7,8,9, io_out_ready = 1 -> outputs 7,8,9 on consecutive cycles, count 1 each.

Source files
------------

// File: rtl/window_sum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : window_sum_accumulator
//  Purpose  : Sums WINDOW consecutive handshaked samples into a widened total
//             and holds each total (or a flushed partial) on a valid/ready port.
//  Revision : 1.0 - initial release
// ============================================================================
module window_sum_accumulator #(
    parameter  int WIDTH     = 32,
    parameter  int WINDOW    = 4,
    localparam int ACC_WIDTH = WIDTH + $clog2(WINDOW),
    localparam int CNT_WIDTH = $clog2(WINDOW + 1)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     io_in_bits,
    input  logic                 io_in_valid,
    output logic                 io_in_ready,
    input  logic                 io_flush,
    output logic [ACC_WIDTH-1:0] io_out_bits,
    output logic [CNT_WIDTH-1:0] io_out_count,
    output logic                 io_out_valid,
    input  logic                 io_out_ready
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(WINDOW - 1);
    localparam bit                   SINGLE    = (WINDOW == 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   acc_nxt;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   cnt_nxt;
    logic [ACC_WIDTH-1:0]   out_bits;
    logic [ACC_WIDTH-1:0]   out_bits_nxt;
    logic [CNT_WIDTH-1:0]   out_count;
    logic [CNT_WIDTH-1:0]   out_count_nxt;

    logic                   in_fire;
    logic                   out_fire;
    logic [ACC_WIDTH-1:0]   in_ext;
    logic [ACC_WIDTH-1:0]   acc_plus_in;
    logic [CNT_WIDTH-1:0]   cnt_plus_fire;
    logic                   window_done;
    logic                   flush_take;

    // Ready is only coupled to the downstream while a result is parked.
    assign io_in_ready  = (state == ACCUM) | io_out_ready;
    assign io_out_valid = (state == HOLD);
    assign io_out_bits  = out_bits;
    assign io_out_count = out_count;

    assign in_fire       = io_in_valid & io_in_ready;
    assign out_fire      = io_out_valid & io_out_ready;
    assign in_ext        = ACC_WIDTH'(io_in_bits);
    assign acc_plus_in   = acc + (in_fire ? in_ext : '0);
    assign cnt_plus_fire = cnt + CNT_WIDTH'(in_fire);
    assign window_done   = in_fire & (cnt == LAST_CNT);
    assign flush_take    = io_flush & ((cnt != '0) | in_fire);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_bits  <= '0;
            out_count <= '0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            out_bits  <= out_bits_nxt;
            out_count <= out_count_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        out_bits_nxt  = out_bits;
        out_count_nxt = out_count;

        case (state)
            ACCUM: begin
                // A completing sample yields cnt_plus_fire == WINDOW, so the
                // full-window and flush loads share one path.
                if (window_done || flush_take) begin
                    out_bits_nxt  = acc_plus_in;
                    out_count_nxt = cnt_plus_fire;
                    acc_nxt       = '0;
                    cnt_nxt       = '0;
                    state_nxt     = HOLD;
                end else if (in_fire) begin
                    acc_nxt = acc_plus_in;
                    cnt_nxt = cnt_plus_fire;
                end
            end
            HOLD: begin
                if (out_fire) begin
                    if (in_fire && SINGLE) begin
                        out_bits_nxt  = in_ext;
                        out_count_nxt = CNT_WIDTH'(1);
                        acc_nxt       = '0;
                        cnt_nxt       = '0;
                    end else begin
                        // Outputs read zero whenever nothing is held.
                        out_bits_nxt  = '0;
                        out_count_nxt = '0;
                        acc_nxt       = in_fire ? in_ext : '0;
                        cnt_nxt       = CNT_WIDTH'(in_fire);
                        state_nxt     = ACCUM;
                    end
                end
            end
            default: begin
                state_nxt = ACCUM;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_window_sum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_window_sum_accumulator
//  Purpose  : Scoreboard bench driving WINDOW=4 and WINDOW=1 instances with a
//             shared stimulus stream against a queue-based window model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_window_sum_accumulator;

    typedef struct {
        longint unsigned sum;
        int              cnt;
    } res_t;

    logic        clock;
    logic        reset_n;
    logic [31:0] in_bits;
    logic        in_valid;
    logic        flush;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial clock = 1'b0;
    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int W  = (g == 0) ? 4 : 1;
        localparam int AW = 32 + $clog2(W);
        localparam int CW = $clog2(W + 1);

        logic          in_ready;
        logic          out_valid;
        logic [AW-1:0] out_bits;
        logic [CW-1:0] out_count;

        window_sum_accumulator #(.WIDTH(32), .WINDOW(W)) u_dut (
            .clock        (clock),
            .reset_n      (reset_n),
            .io_in_bits   (in_bits),
            .io_in_valid  (in_valid),
            .io_in_ready  (in_ready),
            .io_flush     (flush),
            .io_out_bits  (out_bits),
            .io_out_count (out_count),
            .io_out_valid (out_valid),
            .io_out_ready (out_ready)
        );

        res_t            exp_q[$];
        longint unsigned win[$];
        bit              hold = 1'b0;

        // Reference: a list of accepted samples is emitted as one total when
        // it reaches W entries or when a flush arrives with no result parked.
        always @(negedge clock or negedge reset_n) begin : model
            bit              ex_ready;
            bit              in_f;
            bit              out_f;
            bit              nh;
            longint unsigned s;
            if (!reset_n) begin
                win.delete();
                exp_q.delete();
                hold <= 1'b0;
            end else begin
                ex_ready = !hold || out_ready;
                check($sformatf("in_ready[W=%0d]", W), 64'(in_ready), 64'(ex_ready));
                check($sformatf("out_valid[W=%0d]", W), 64'(out_valid), 64'(hold));
                in_f = in_valid && ex_ready;
                out_f = hold && out_ready;
                nh = hold && !out_f;
                if (in_f) win.push_back(longint'(in_bits));
                if (win.size() == W || (flush && !hold && win.size() > 0)) begin
                    s = 0;
                    foreach (win[i]) s += win[i];
                    exp_q.push_back('{s, win.size()});
                    win.delete();
                    nh = 1'b1;
                end
                hold <= nh;
            end
        end

        always @(negedge clock) begin : monitor
            res_t r;
            if (reset_n) begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_out[W=%0d]: got %0h expected none", W, out_bits);
                    end else begin
                        r = exp_q.pop_front();
                        check($sformatf("out_bits[W=%0d]", W), 64'(out_bits), r.sum);
                        check($sformatf("out_count[W=%0d]", W), 64'(out_count), 64'(r.cnt));
                    end
                end else if (out_valid) begin
                    if (exp_q.size() > 0)
                        check($sformatf("stall_bits[W=%0d]", W), 64'(out_bits), exp_q[0].sum);
                end else begin
                    check($sformatf("idle_bits[W=%0d]", W), 64'(out_bits), 64'd0);
                    check($sformatf("idle_count[W=%0d]", W), 64'(out_count), 64'd0);
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] d, input logic f, input logic r);
        in_valid  = v;
        in_bits   = d;
        flush     = f;
        out_ready = r;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; in_bits = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", 64'(g_dut[0].in_ready), 64'd1);
        check("rst_out_valid", 64'(g_dut[0].out_valid), 64'd0);
        check("rst_out_bits", 64'(g_dut[0].out_bits), 64'd0);
        check("rst_out_count", 64'(g_dut[0].out_count), 64'd0);
        reset_n = 1'b1;
        cyc(0, 0, 0, 1);

        // 1,2,3,4 back to back
        for (int i = 1; i <= 4; i++) cyc(1, 32'(i), 0, 1);
        check("win_sum_10", 64'(g_dut[0].out_bits), 64'd10);
        check("win_cnt_4", 64'(g_dut[0].out_count), 64'd4);
        check("win_in_ready", 64'(g_dut[0].in_ready), 64'd1);
        cyc(0, 0, 0, 1);

        // full-scale window does not wrap
        repeat (4) cyc(1, 32'hFFFF_FFFF, 0, 1);
        check("max_sum", 64'(g_dut[0].out_bits), 64'h3_FFFF_FFFC);
        cyc(0, 0, 0, 1);

        // downstream stall with a sample waiting
        cyc(1, 5, 0, 1); cyc(1, 6, 0, 1); cyc(1, 7, 0, 1); cyc(1, 8, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 9, 0, 0);
            check("stall_in_ready", 64'(g_dut[0].in_ready), 64'd0);
            check("stall_hold_26", 64'(g_dut[0].out_bits), 64'd26);
        end
        cyc(1, 9, 0, 1);
        repeat (3) cyc(1, 1, 0, 1);
        check("next_win_12", 64'(g_dut[0].out_bits), 64'd12);
        cyc(0, 0, 0, 1);

        // flush behaviour
        cyc(1, 3, 0, 1); cyc(1, 4, 0, 1); cyc(0, 0, 1, 1);
        check("flush_sum_7", 64'(g_dut[0].out_bits), 64'd7);
        check("flush_cnt_2", 64'(g_dut[0].out_count), 64'd2);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 1);
        check("flush_empty", 64'(g_dut[0].out_valid), 64'd0);
        cyc(1, 3, 0, 1); cyc(1, 4, 0, 1); cyc(1, 5, 1, 1);
        check("flush_in_12", 64'(g_dut[0].out_bits), 64'd12);
        check("flush_in_cnt3", 64'(g_dut[0].out_count), 64'd3);
        cyc(0, 0, 0, 1);

        // asynchronous reset pulse mid-window
        cyc(1, 1, 0, 1); cyc(1, 1, 0, 1);
        in_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("async_valid_w4", 64'(g_dut[0].out_valid), 64'd0);
        check("async_valid_w1", 64'(g_dut[1].out_valid), 64'd0);
        check("async_in_ready", 64'(g_dut[0].in_ready), 64'd1);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;
        repeat (4) cyc(1, 1, 0, 1);
        check("post_rst_sum", 64'(g_dut[0].out_bits), 64'd4);
        check("post_rst_cnt", 64'(g_dut[0].out_count), 64'd4);
        cyc(0, 0, 0, 1);

        // single-sample windows stream without bubbles
        cyc(1, 7, 0, 1);
        check("w1_7", 64'(g_dut[1].out_bits), 64'd7);
        cyc(1, 8, 0, 1);
        check("w1_8", 64'(g_dut[1].out_bits), 64'd8);
        cyc(1, 9, 0, 1);
        check("w1_9", 64'(g_dut[1].out_bits), 64'd9);
        check("w1_cnt", 64'(g_dut[1].out_count), 64'd1);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cyc($urandom_range(0, 3) != 0,
                ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom),
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) < 6);
        end

        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 1);
        repeat (4) cyc(0, 0, 0, 1);
        check("drain_w4", 64'(g_dut[0].exp_q.size()), 64'd0);
        check("drain_w1", 64'(g_dut[1].exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
